// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared float format constants, status codes and converter states
package fpu_pkg;

    localparam int BIAS  = 31;
    localparam int EXP_W = 6;
    localparam int MAN_W = 25;

    localparam logic [3:0] ST_EXACT     = 4'b0001;
    localparam logic [3:0] ST_INEXACT   = 4'b1111;
    localparam logic [3:0] ST_OVERFLOW  = 4'b0011;
    localparam logic [3:0] ST_UNDERFLOW = 4'b0111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        PACK  = 2'd3
    } state_t;

endpackage

// File: rtl/fp_unpack.sv
// rtl/fp_unpack.sv - combinational field split of a packed float word
module fp_unpack
    import fpu_pkg::*;
(
    input  logic [31:0]          op,
    output logic                 sign,
    output logic signed [EXP_W:0] exp,
    output logic [MAN_W:0]       sig,
    output logic                 is_zero
);

    localparam logic signed [EXP_W:0] BIAS_S = (EXP_W+1)'(BIAS);

    assign sign    = op[31];
    assign exp     = $signed({1'b0, op[30:25]}) - BIAS_S;
    assign sig     = {1'b1, op[24:0]};
    assign is_zero = (op[30:0] == 31'd0);

endmodule

// File: rtl/fp_to_int.sv
// rtl/fp_to_int.sv - sequential float to integer converter, truncating toward zero
module fp_to_int
    import fpu_pkg::*;
#(
    parameter bit SATURATE = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_in,
    input  logic [31:0] op_in,
    output logic        busy_out,
    output logic        done_out,
    output logic [31:0] data_out,
    output logic [3:0]  status_out
);

    localparam logic signed [EXP_W:0] MAN_S = (EXP_W+1)'(MAN_W);

    state_t               state;
    logic [31:0]          op_q;
    logic [31:0]          mag;
    logic [4:0]           cnt;
    logic                 sticky;
    logic                 right;
    logic                 special;
    logic [3:0]           stat;

    logic                 sign;
    logic signed [EXP_W:0] exp;
    logic [MAN_W:0]       sig;
    logic                 is_zero;
    logic [4:0]           n_right;
    logic [4:0]           n_left;
    logic [31:0]          ovf_val;

    fp_unpack u_unpack (
        .op      (op_q),
        .sign    (sign),
        .exp     (exp),
        .sig     (sig),
        .is_zero (is_zero)
    );

    // Only the low exponent bits matter inside the shifting ranges 0..30.
    assign n_right = 5'd25 - exp[4:0];
    assign n_left  = exp[4:0] - 5'd25;
    assign ovf_val = SATURATE ? (sign ? 32'h8000_0000 : 32'h7FFF_FFFF) : 32'h0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= '0;
            mag        <= '0;
            cnt        <= '0;
            sticky     <= 1'b0;
            right      <= 1'b0;
            special    <= 1'b0;
            stat       <= '0;
            busy_out   <= 1'b0;
            done_out   <= 1'b0;
            data_out   <= '0;
            status_out <= '0;
        end else begin
            done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_in) begin
                        op_q     <= op_in;
                        busy_out <= 1'b1;
                        state    <= LOAD;
                    end
                end
                LOAD: begin
                    sticky  <= 1'b0;
                    special <= 1'b1;
                    right   <= 1'b0;
                    cnt     <= '0;
                    mag     <= '0;
                    stat    <= ST_EXACT;
                    state   <= PACK;
                    if (is_zero) begin
                        stat <= ST_EXACT;
                    end else if (exp < 7'sd0) begin
                        stat <= ST_UNDERFLOW;
                    end else if (exp <= MAN_S) begin
                        special <= 1'b0;
                        right   <= 1'b1;
                        mag     <= {6'd0, sig};
                        cnt     <= n_right;
                        if (n_right != 5'd0)
                            state <= SHIFT;
                    end else if (exp <= MAN_S + 7'sd5) begin
                        special <= 1'b0;
                        mag     <= {6'd0, sig};
                        cnt     <= n_left;
                        state   <= SHIFT;
                    end else if (exp == MAN_S + 7'sd6 && sign && sig[MAN_W-1:0] == '0) begin
                        mag <= 32'h8000_0000;
                    end else begin
                        stat <= ST_OVERFLOW;
                        mag  <= ovf_val;
                    end
                end
                SHIFT: begin
                    if (right) begin
                        mag    <= mag >> 1;
                        sticky <= sticky | mag[0];
                    end else begin
                        mag <= mag << 1;
                    end
                    cnt <= cnt - 5'd1;
                    if (cnt == 5'd1)
                        state <= PACK;
                end
                PACK: begin
                    data_out   <= (special || !sign) ? mag : (~mag + 32'd1);
                    status_out <= special ? stat : (sticky ? ST_INEXACT : ST_EXACT);
                    done_out   <= 1'b1;
                    busy_out   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_to_int.sv
// tb/tb_fp_to_int.sv - randomized self-checking bench for fp_to_int against an arithmetic model
module tb_fp_to_int;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start_in = 1'b0;
    logic [31:0] op_in = 32'd0;

    logic        busy_s, done_s, busy_z, done_z;
    logic [31:0] data_s, data_z;
    logic [3:0]  status_s, status_z;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    fp_to_int #(.SATURATE(1'b1)) dut_sat (
        .clock(clock), .reset(reset), .start_in(start_in), .op_in(op_in),
        .busy_out(busy_s), .done_out(done_s), .data_out(data_s), .status_out(status_s)
    );

    fp_to_int #(.SATURATE(1'b0)) dut_nosat (
        .clock(clock), .reset(reset), .start_in(start_in), .op_in(op_in),
        .busy_out(busy_z), .done_out(done_z), .data_out(data_z), .status_out(status_z)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Value = sig * 2^(e-25); out-of-range is decided on the signed value itself.
    task automatic model(input logic [31:0] op, input bit sat,
                         output logic [31:0] d, output logic [3:0] st, output int lat);
        int     e;
        longint sig, mag, val;
        bit     inex;
        e   = int'(op[30:25]) - 31;
        sig = longint'({1'b1, op[24:0]});
        lat = 3;
        if (op[30:0] == 31'd0) begin
            d = 32'd0; st = 4'b0001;
        end else if (e < 0) begin
            d = 32'd0; st = 4'b0111;
        end else begin
            if (e >= 25) begin
                mag  = sig << (e - 25);
                inex = 1'b0;
            end else begin
                mag  = sig >> (25 - e);
                inex = (sig & ((64'd1 << (25 - e)) - 1)) != 0;
            end
            val = op[31] ? -mag : mag;
            if (val > 64'sd2147483647 || val < -64'sd2147483648) begin
                st = 4'b0011;
                d  = sat ? (op[31] ? 32'h8000_0000 : 32'h7FFF_FFFF) : 32'd0;
            end else begin
                d  = val[31:0];
                st = inex ? 4'b1111 : 4'b0001;
            end
            if (e <= 30)
                lat = 3 + ((e >= 25) ? (e - 25) : (25 - e));
        end
    endtask

    task automatic run_op(input logic [31:0] op, input bit hold, input string tag);
        logic [31:0] d_s, d_z;
        logic [3:0]  st_s, st_z;
        int          lat, lat_z, edges;
        bit          got;
        model(op, 1'b1, d_s, st_s, lat);
        model(op, 1'b0, d_z, st_z, lat_z);
        @(negedge clock);
        start_in = 1'b1;
        op_in    = op;
        edges    = 0;
        got      = 1'b0;
        while (!got && edges < 40) begin
            @(posedge clock);
            edges++;
            #1;
            if (edges == 1)
                check({tag, "_busy_edge1"}, 32'(busy_s), 32'd1);
            if (hold)
                op_in = $urandom;
            else
                start_in = 1'b0;
            if (done_s)
                got = 1'b1;
        end
        start_in = 1'b0;
        check({tag, "_latency"}, 32'(edges), 32'(lat));
        check({tag, "_data"}, data_s, d_s);
        check({tag, "_status"}, 32'(status_s), 32'(st_s));
        check({tag, "_busy_done"}, 32'(busy_s), 32'd0);
        check({tag, "_nosat_done"}, 32'(done_z), 32'd1);
        check({tag, "_nosat_data"}, data_z, d_z);
        check({tag, "_nosat_status"}, 32'(status_z), 32'(st_z));
        @(posedge clock);
        #1;
        check({tag, "_done_width"}, 32'(done_s), 32'd0);
    endtask

    initial begin
        int pulses;
        repeat (3) @(posedge clock);
        #1;
        check("reset_busy", 32'(busy_s), 32'd0);
        check("reset_done", 32'(done_s), 32'd0);
        check("reset_data", data_s, 32'd0);
        check("reset_status", 32'(status_s), 32'd0);
        reset = 1'b0;

        run_op(32'h3E00_0000, 1'b0, "one");
        run_op(32'hC080_0000, 1'b0, "neg2p5");
        run_op(32'h3C00_0000, 1'b0, "half");
        run_op(32'h8000_0000, 1'b0, "negzero");
        run_op(32'h0000_0000, 1'b0, "zero");
        run_op(32'h0000_0001, 1'b0, "tiny");
        run_op(32'h7A00_0000, 1'b0, "two30");
        run_op(32'h7C00_0000, 1'b0, "pos2_31");
        run_op(32'hFC00_0000, 1'b0, "neg2_31");
        run_op(32'hFC00_0001, 1'b0, "neg2_31p");
        run_op(32'h7FFF_FFFF, 1'b0, "maxexp");
        run_op(32'h7BFF_FFFF, 1'b0, "max_fit");
        run_op(32'h3E00_0000, 1'b1, "hold_start");

        for (int i = 0; i < 150; i++)
            run_op($urandom, 1'b0, "rand");
        for (int i = 0; i < 100; i++)
            run_op({1'($urandom), 6'($urandom_range(31, 62)), 25'($urandom)}, 1'b0, "rand_mid");

        // Reset during a conversion: busy drops, no done follows, outputs clear.
        run_op(32'h7A00_0000, 1'b0, "pre_reset");
        @(negedge clock);
        start_in = 1'b1;
        op_in    = 32'h3E00_0000;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clock);
            #1;
            start_in = 1'b0;
        end
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("abort_busy", 32'(busy_s), 32'd0);
        check("abort_done", 32'(done_s), 32'd0);
        check("abort_data", data_s, 32'd0);
        check("abort_status", 32'(status_s), 32'd0);
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clock);
            #1;
            if (done_s || busy_s)
                pulses++;
        end
        check("abort_quiet", 32'(pulses), 32'd0);
        run_op(32'hC080_0000, 1'b0, "post_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp_to_int.md
# fp_to_int

Sequential converter from the team's 32-bit custom float format to a 32-bit two's-complement integer. It is the read-back direction for results produced by the FPU adder: it consumes packed float words and returns integers with truncation toward zero. It reports status with the same 4-bit codes the adder uses. It processes one operand at a time with a start/done handshake, and its shifter advances one bit per cycle.

## Interface
- `SATURATE`, default 1: on overflow, drive the saturated integer (1) or 0 (0).
- `clock` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high reset.
- `start_in` in 1: request conversion of `op_in`; sampled only in IDLE.
- `op_in` in 32: float operand. [31] sign, [30:25] exponent (bias 31), [24:0] mantissa with implicit leading 1.
- `busy_out` out 1: conversion in progress.
- `done_out` out 1: one-cycle pulse; `data_out`/`status_out` are valid from this cycle.
- `data_out` out 32: signed integer result; held until the next done.
- `status_out` out 4: 0001 exact, 1111 inexact, 0011 overflow, 0111 underflow; held until the next done.

## Operation
- Input value = (-1)^s × 1.m × 2^e, where e = exp − 31. Significand sig = {1, m} is 26 bits, so value = sig × 2^(e−25).
- FSM states are IDLE, LOAD, SHIFT and PACK.
  - IDLE: if `start_in`, capture `op_in`, go to LOAD, and raise `busy_out`.
  - LOAD classifies the operand, sets the shift count n and direction, then goes to SHIFT if n > 0, else to PACK.
    - Zero: exp field 0 and mantissa 0, either sign. Result 0, status 0001, n = 0.
    - e < 0 (any other operand with exp < 31): |x| < 1. Result 0, status 0111, n = 0.
    - 0 ≤ e ≤ 25: right shift, n = 25 − e.
    - 26 ≤ e ≤ 30: left shift, n = e − 25 (max 5).
    - e = 31, sign 1, mantissa 0: exactly −2^31. Result 0x80000000, status 0001, n = 0.
    - All other e ≥ 31: overflow, status 0011, n = 0. Result 0x7FFFFFFF (positive) or 0x80000000 (negative) when `SATURATE` = 1, otherwise 0.
  - SHIFT performs one bit shift per cycle on a 32-bit magnitude register and decrements n; it goes to PACK when n reaches 0.
    - On right shifts, a sticky bit ORs in every bit shifted out.
  - PACK negates the magnitude if sign = 1 and the path is not special.
    - Status: 1111 if sticky, else 0001.
    - Registers `data_out`/`status_out`, pulses `done_out`, clears `busy_out`, and returns to IDLE.
- Rounding is truncation toward zero only. Example: −2.5 converts to −2 (inexact).
- `start_in` outside IDLE is ignored; requests are not queued.
- Reset mid-conversion aborts the operation. No done pulse follows, and all outputs return to their reset values.

## Timing
- Reset values: `busy_out` 0, `done_out` 0, `data_out` 0x00000000, `status_out` 0000, state IDLE, internal registers 0.
- The edge that samples `start_in` is edge 1.
  - LOAD occupies edge 2.
  - SHIFT occupies edges 3 … n+2.
  - PACK is edge n+3: it sets `done_out` = 1 and `busy_out` = 0.
- Latency is n + 3 edges from start sampling to the done-asserting edge. This gives 3 edges for special cases and up to 28 edges at e = 0.
- `busy_out` is high from edge 1 through the cycle before done. In the done cycle, `busy_out` = 0 and state = IDLE.
- A `start_in` sampled in the done cycle begins a new conversion: back-to-back throughput is n + 3 cycles.
- `done_out` is exactly one cycle wide.

## Structure
- Shared package `fpu_pkg` holds:
  - constants BIAS = 31, EXP_W = 6, MAN_W = 25;
  - the status code constants 0001/1111/0011/0111;
  - the FSM state enum typedef.
- The FPU adder migrates to `fpu_pkg` as well.
- Sub-module `fp_unpack` is a combinational field split (sign, unbiased signed exponent, 26-bit significand, zero flag), reusable by the adder. Everything else lives in `fp_to_int`.

## Test plan
- `op_in` = 0x3E000000 (1.0) → `data_out` 0x00000001, status 0001, done on edge 28 (n = 25).
- `op_in` = 0xC0800000 (−2.5) → `data_out` 0xFFFFFFFE, status 1111.
- `op_in` = 0x3C000000 (0.5) → 0x00000000, status 0111, done on edge 3. `op_in` = 0x80000000 (−0) → 0, status 0001.
- `op_in` = 0x7A000000 (2^30) → 0x40000000, status 0001, done on edge 8 (n = 5).
- `op_in` = 0x7C000000 (+2^31) → 0x7FFFFFFF, status 0011. `op_in` = 0xFC000000 (−2^31) → 0x80000000, status 0001. With `SATURATE` = 0, +2^31 → 0, status 0011.
- Hold `start_in` high during a 1.0 conversion with a changing `op_in`: only the first operand is converted. Assert `reset` on edge 10 of a second conversion: `busy_out` 0, no `done_out` pulse, outputs 0.
